// File: rtl/dmux4_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmux4_dispatch_pkg
// Brief   : Shared constants and types for the 1-to-4 byte dispatch stage.
// Revision: 1.0 - initial release
// ============================================================================
package dmux4_dispatch_pkg;

    localparam int CH_N   = 4;   // number of demux output channels
    localparam int CH_W   = 2;   // width of a channel index
    localparam int BYTE_W = 8;   // width of a dispatched byte

    typedef logic [CH_W-1:0] ch_idx_t;

    // One-hot channel mask for a channel index.
    function automatic logic [CH_N-1:0] ch_onehot(input ch_idx_t idx);
        logic [CH_N-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage : dmux4_dispatch_pkg
`default_nettype wire

// File: rtl/dmux4_dispatch_rr_pick4.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick4
// Brief   : Combinational round-robin channel picker. Starting at rr_ptr,
//           returns the first channel that is not busy when skip_en is set;
//           falls back to rr_ptr when skipping is off or all are busy.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick4
    import dmux4_dispatch_pkg::*;
(
    input  ch_idx_t         rr_ptr,
    input  logic [CH_N-1:0] busy,
    input  logic            skip_en,
    output ch_idx_t         idx
);

    ch_idx_t w_cand;

    // Scan from the farthest candidate back to rr_ptr so the nearest free one wins.
    always_comb begin
        idx    = rr_ptr;
        w_cand = rr_ptr;
        if (skip_en) begin
            for (int k = CH_N - 1; k >= 0; k--) begin
                w_cand = rr_ptr + ch_idx_t'(k);
                if (!busy[w_cand]) begin
                    idx = w_cand;
                end
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/dmux4_dispatch.sv
`default_nettype none
// ============================================================================
// Module  : dmux4_dispatch
// Brief   : Upstream control stage for the 8-bit 1-to-4 demultiplexer.
//           Accepts a valid/ready byte stream, assigns each byte a channel in
//           round-robin order (optionally skipping busy consumers), holds it
//           in a one-entry stage until that consumer is free, and drives the
//           demux data/select plus a one-hot per-channel load strobe.
// Revision: 1.0 - initial release
// ============================================================================
module dmux4_dispatch
    import dmux4_dispatch_pkg::*;
#(
    parameter bit SKIP_BUSY = 1'b1,
    parameter int CNT_W     = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_N-1:0]   ch_busy,
    output logic [BYTE_W-1:0] dmux_a,
    output logic [CH_W-1:0]   dmux_sel,
    output logic [CH_N-1:0]   ch_load,
    output logic [CNT_W-1:0]  sent_cnt
);

    // Stage state
    logic              r_hold_valid;
    logic [BYTE_W-1:0] r_hold_data;
    ch_idx_t           r_hold_sel;
    ch_idx_t           r_rr_ptr;
    logic [CNT_W-1:0]  r_sent_cnt;

    // Per-cycle decisions
    logic              w_disp;
    logic              w_acc;
    ch_idx_t           w_pick;

    // The held byte leaves whenever its own consumer is free this cycle;
    // the channel never changes after accept.
    assign w_disp   = r_hold_valid & ~ch_busy[r_hold_sel];

    // The stage can refill in the same cycle it drains, giving one byte/cycle.
    assign in_ready = en & (~r_hold_valid | w_disp);
    assign w_acc    = in_valid & in_ready;

    rr_pick4 u_pick (
        .rr_ptr  (r_rr_ptr),
        .busy    (ch_busy),
        .skip_en (SKIP_BUSY),
        .idx     (w_pick)
    );

    // Load strobe is the one-hot of the held channel while dispatching.
    always_comb begin
        ch_load = '0;
        if (w_disp) begin
            ch_load = ch_onehot(r_hold_sel);
        end
    end

    // Data is blanked while empty; select keeps its last channel.
    assign dmux_a   = r_hold_valid ? r_hold_data : '0;
    assign dmux_sel = r_hold_sel;
    assign sent_cnt = r_sent_cnt;

    // Hold register: load on accept (overrides drain), clear on drain alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
            r_hold_sel   <= '0;
        end else if (w_acc) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= in_data;
            r_hold_sel   <= w_pick;
        end else if (w_disp) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Round-robin pointer advances past the chosen channel only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_acc) begin
            r_rr_ptr <= w_pick + ch_idx_t'(1);
        end
    end

    // Dispatched-byte counter, free-running modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sent_cnt <= '0;
        end else if (w_disp) begin
            r_sent_cnt <= r_sent_cnt + CNT_W'(1);
        end
    end

endmodule : dmux4_dispatch
`default_nettype wire
